// File: rtl/psx_poll_scheduler.sv
// psx_poll_scheduler: alternates digital poll frames between two PSX pad ports.
// It frames each port with its own ATT line and feeds the 5-byte poll command to a
// shared byte engine. Each byte's ACK and the 0x5A marker are checked, and the
// button/ID state is latched when a frame completes cleanly.
module psx_poll_scheduler #(
    parameter logic [31:0] POLL_PERIOD  = 32'd8000,
    parameter logic [31:0] ATT_SETUP    = 32'd40,
    parameter logic [31:0] BYTE_GAP     = 32'd20,
    parameter logic [31:0] ATT_HOLD     = 32'd30,
    parameter logic [31:0] DONE_TIMEOUT = 32'd400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        xfer_start,
    output logic [7:0]  xfer_tx_byte,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx_byte,
    input  logic        xfer_ack,
    output logic [1:0]  att_n,
    output logic [15:0] buttons0,
    output logic [15:0] buttons1,
    output logic [7:0]  pad_id0,
    output logic [7:0]  pad_id1,
    output logic [1:0]  present,
    output logic [1:0]  update_stb
);

    // Terminal counts. A zero parameter still yields a one-cycle phase.
    localparam logic [31:0] POLL_LAST    = (POLL_PERIOD  == 32'd0) ? 32'd0 : POLL_PERIOD  - 32'd1;
    localparam logic [31:0] SETUP_LAST   = (ATT_SETUP    == 32'd0) ? 32'd0 : ATT_SETUP    - 32'd1;
    localparam logic [31:0] GAP_LAST     = (BYTE_GAP     == 32'd0) ? 32'd0 : BYTE_GAP     - 32'd1;
    localparam logic [31:0] HOLD_LAST    = (ATT_HOLD     == 32'd0) ? 32'd0 : ATT_HOLD     - 32'd1;
    localparam logic [31:0] TIMEOUT_LAST = (DONE_TIMEOUT == 32'd0) ? 32'd0 : DONE_TIMEOUT - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_GAP     = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    // Digital poll command: 0x01, 0x42, then three 0x00 bytes.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h01;
            3'd1:    b = 8'h42;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Bytes 0..3 need an ACK. Byte 2 must also return the 0x5A marker. Byte 4 needs no ACK.
    function automatic logic byte_valid(input logic [2:0] idx, input logic [7:0] rx, input logic ack);
        return ((idx == 3'd4) || ack) && ((idx != 3'd2) || (rx == 8'h5A));
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        port_q, port_d;
    logic [2:0]  k_q, k_d;
    logic [1:0]  att_n_q, att_n_d;
    logic        xfer_start_q, xfer_start_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [15:0] buttons0_q, buttons0_d, buttons1_q, buttons1_d;
    logic [7:0]  pad_id0_q, pad_id0_d, pad_id1_q, pad_id1_d;
    logic [1:0]  present_q, present_d;
    logic [1:0]  update_stb_q, update_stb_d;
    logic [7:0]  rx1_q, rx1_d, rx3_q, rx3_d;
    logic        rel_enter_s, rel_ok_s;

    // Next-state logic, with frame-close updates of the per-port outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        k_d          = k_q;
        att_n_d      = att_n_q;
        xfer_start_d = 1'b0;
        tx_byte_d    = tx_byte_q;
        buttons0_d   = buttons0_q;
        buttons1_d   = buttons1_q;
        pad_id0_d    = pad_id0_q;
        pad_id1_d    = pad_id1_q;
        present_d    = present_q;
        update_stb_d = 2'b00;
        rx1_d        = rx1_q;
        rx3_d        = rx3_q;
        rel_enter_s  = 1'b0;
        rel_ok_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cnt_q >= POLL_LAST) begin
                    if (enable) begin
                        state_d = S_SETUP;
                        cnt_d   = 32'd0;
                        port_d  = 1'b0;
                        k_d     = 3'd0;
                        att_n_d = 2'b10;
                    end else begin
                        cnt_d = cnt_q;          // saturated until enable is seen
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SETUP, S_GAP: begin
                if (cnt_q >= ((state_q == S_SETUP) ? SETUP_LAST : GAP_LAST)) begin
                    state_d      = S_START;
                    cnt_d        = 32'd0;
                    xfer_start_d = 1'b1;
                    tx_byte_d    = cmd_byte(k_q);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = 32'd0;
            end
            S_WAIT: begin
                if (xfer_done) begin
                    case (k_q)
                        3'd1:    rx1_d = xfer_rx_byte;
                        3'd3:    rx3_d = xfer_rx_byte;
                        default: rx1_d = rx1_q;
                    endcase
                    if (!byte_valid(k_q, xfer_rx_byte, xfer_ack)) begin
                        rel_enter_s = 1'b1;
                    end else if (k_q == 3'd4) begin
                        rel_enter_s = 1'b1;
                        rel_ok_s    = 1'b1;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = S_GAP;
                        cnt_d   = 32'd0;
                    end
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    rel_enter_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RELEASE: begin
                if (cnt_q >= HOLD_LAST) begin
                    cnt_d = 32'd0;
                    k_d   = 3'd0;
                    if (port_q == 1'b0) begin
                        state_d = S_SETUP;
                        port_d  = 1'b1;
                        att_n_d = 2'b01;
                    end else begin
                        state_d = S_IDLE;
                        port_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
                att_n_d = 2'b11;
            end
        endcase

        // Frame end: raise ATT, then publish the result on the same edge.
        if (rel_enter_s) begin
            state_d = S_RELEASE;
            cnt_d   = 32'd0;
            att_n_d = 2'b11;
            if (port_q == 1'b0) begin
                present_d[0]    = rel_ok_s;
                buttons0_d      = rel_ok_s ? {xfer_rx_byte, rx3_q} : 16'hFFFF;
                pad_id0_d       = rel_ok_s ? rx1_q : pad_id0_q;
                update_stb_d[0] = rel_ok_s;
            end else begin
                present_d[1]    = rel_ok_s;
                buttons1_d      = rel_ok_s ? {xfer_rx_byte, rx3_q} : 16'hFFFF;
                pad_id1_d       = rel_ok_s ? rx1_q : pad_id1_q;
                update_stb_d[1] = rel_ok_s;
            end
        end else begin
            update_stb_d = 2'b00;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'd0;
            port_q       <= 1'b0;
            k_q          <= 3'd0;
            att_n_q      <= 2'b11;
            xfer_start_q <= 1'b0;
            tx_byte_q    <= 8'hFF;
            buttons0_q   <= 16'hFFFF;
            buttons1_q   <= 16'hFFFF;
            pad_id0_q    <= 8'h00;
            pad_id1_q    <= 8'h00;
            present_q    <= 2'b00;
            update_stb_q <= 2'b00;
            rx1_q        <= 8'h00;
            rx3_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            k_q          <= k_d;
            att_n_q      <= att_n_d;
            xfer_start_q <= xfer_start_d;
            tx_byte_q    <= tx_byte_d;
            buttons0_q   <= buttons0_d;
            buttons1_q   <= buttons1_d;
            pad_id0_q    <= pad_id0_d;
            pad_id1_q    <= pad_id1_d;
            present_q    <= present_d;
            update_stb_q <= update_stb_d;
            rx1_q        <= rx1_d;
            rx3_q        <= rx3_d;
        end
    end

    assign att_n        = att_n_q;
    assign xfer_start   = xfer_start_q;
    assign xfer_tx_byte = tx_byte_q;
    assign buttons0     = buttons0_q;
    assign buttons1     = buttons1_q;
    assign pad_id0      = pad_id0_q;
    assign pad_id1      = pad_id1_q;
    assign present      = present_q;
    assign update_stb   = update_stb_q;

endmodule

// File: tb/tb_psx_poll_scheduler.sv
// Scoreboard bench for psx_poll_scheduler. An engine model answers byte requests
// from per-frame scenarios. A frame-level reference model predicts the command
// bytes, the frame outcome and the ATT-low duration. A monitor compares these
// predictions with what the DUT produces.
module tb_psx_poll_scheduler;

    localparam int POLL = 100;
    localparam int SETUP = 40;
    localparam int GAP = 20;
    localparam int HOLD = 30;
    localparam int TMO = 400;

    typedef struct {
        logic [4:0][7:0] rx;
        logic [4:0]      ack;
        logic [4:0][7:0] lat;
        int              nodone;   // byte index the engine never completes (5 = none)
    } scn_t;

    typedef struct {
        int          port;
        bit          ok;
        logic [15:0] buttons;
        logic [7:0]  pad;
        int          n_starts;
        int          low_cycles;
    } exp_t;

    logic        clk, rst, enable;
    logic        xfer_start, xfer_done, xfer_ack;
    logic [7:0]  xfer_tx_byte, xfer_rx_byte;
    logic [1:0]  att_n, present, update_stb;
    logic [15:0] buttons0, buttons1;
    logic [7:0]  pad_id0, pad_id1;

    psx_poll_scheduler #(
        .POLL_PERIOD(32'(POLL)), .ATT_SETUP(32'(SETUP)), .BYTE_GAP(32'(GAP)),
        .ATT_HOLD(32'(HOLD)), .DONE_TIMEOUT(32'(TMO))
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .xfer_start(xfer_start), .xfer_tx_byte(xfer_tx_byte),
        .xfer_done(xfer_done), .xfer_rx_byte(xfer_rx_byte), .xfer_ack(xfer_ack),
        .att_n(att_n), .buttons0(buttons0), .buttons1(buttons1),
        .pad_id0(pad_id0), .pad_id1(pad_id1), .present(present), .update_stb(update_stb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    scn_t scn_q[$];
    exp_t exp_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] model_pad [2];
    int eng_byte = 0;
    bit eng_busy = 1'b0;
    bit spur_req = 1'b0;
    int fall_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event occurred at cycle %0d, required none", name, cyc);
    endtask

    function automatic logic [7:0] cmd_of(input int k);
        if (k == 0) return 8'h01;
        if (k == 1) return 8'h42;
        return 8'h00;
    endfunction

    function automatic scn_t rand_scn(input bit force_good);
        scn_t s;
        for (int k = 0; k < 5; k++) begin
            s.rx[k]  = 8'($urandom);
            s.ack[k] = ($urandom_range(0, 9) != 0);
            s.lat[k] = force_good ? 8'($urandom_range(10, 120)) : 8'($urandom_range(1, 120));
        end
        s.rx[2]  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h5A;
        s.nodone = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 4)) : 5;
        if (force_good) begin
            s.rx[2]  = 8'h5A;
            s.ack    = 5'b11111;
            s.nodone = 5;
        end
        return s;
    endfunction

    // Frame-level reference: apply the poll rules byte by byte to predict the outcome.
    task automatic issue(input scn_t s, input int port);
        exp_t e;
        e.port = port; e.ok = 1'b1; e.n_starts = 0; e.low_cycles = SETUP;
        for (int k = 0; k < 5; k++) begin
            exp_tx_q.push_back(cmd_of(k));
            e.n_starts++;
            if (k == s.nodone) begin
                e.low_cycles += 1 + TMO;
                e.ok = 1'b0;
                break;
            end
            e.low_cycles += 1 + int'(s.lat[k]);
            if ((k < 4 && !s.ack[k]) || (k == 2 && s.rx[2] != 8'h5A)) begin
                e.ok = 1'b0;
                break;
            end
            if (k < 4) e.low_cycles += GAP;
        end
        if (e.ok) begin
            e.buttons = {s.rx[4], s.rx[3]};
            model_pad[port] = s.rx[1];
        end else begin
            e.buttons = 16'hFFFF;
        end
        e.pad = model_pad[port];
        exp_q.push_back(e);
        scn_q.push_back(s);
    endtask

    task automatic check_reset_outputs();
        check("rst_att_n", 32'(att_n), 32'h3);
        check("rst_xfer_start", 32'(xfer_start), 32'h0);
        check("rst_tx_byte", 32'(xfer_tx_byte), 32'hFF);
        check("rst_buttons0", 32'(buttons0), 32'hFFFF);
        check("rst_buttons1", 32'(buttons1), 32'hFFFF);
        check("rst_pad_id0", 32'(pad_id0), 32'h0);
        check("rst_pad_id1", 32'(pad_id1), 32'h0);
        check("rst_present", 32'(present), 32'h0);
        check("rst_update_stb", 32'(update_stb), 32'h0);
    endtask

    // Byte engine model: answers each start after the scenario latency and drops
    // bytes marked nodone. A spurious done is sent 4 cycles after each real done,
    // which lands in GAP or RELEASE.
    initial begin
        scn_t cur;
        int cd, spur;
        logic [1:0] att_prev;
        cur = rand_scn(1'b1);
        cd = 0; spur = 0; att_prev = 2'b11;
        xfer_done = 1'b0; xfer_rx_byte = 8'h00; xfer_ack = 1'b0;
        forever begin
            @(negedge clk);
            xfer_done = 1'b0;
            if (rst) begin
                eng_busy = 1'b0; spur = 0; eng_byte = 0; att_prev = 2'b11;
            end else begin
                if (att_prev == 2'b11 && att_n != 2'b11) begin
                    eng_byte = 0;
                    if (scn_q.size() > 0) cur = scn_q.pop_front();
                    else cur = rand_scn(1'b1);
                end
                att_prev = att_n;
                if (eng_busy) begin
                    cd--;
                    if (cd == 0) begin
                        eng_busy = 1'b0;
                        xfer_done = 1'b1;
                        xfer_rx_byte = cur.rx[eng_byte - 1];
                        xfer_ack = cur.ack[eng_byte - 1];
                        spur = 4;
                    end
                end else if (spur > 0) begin
                    spur--;
                    if (spur == 0) begin
                        xfer_done = 1'b1; xfer_rx_byte = 8'h5A; xfer_ack = 1'b1;
                    end
                end else if (spur_req) begin
                    spur_req = 1'b0;
                    xfer_done = 1'b1; xfer_rx_byte = 8'h5A; xfer_ack = 1'b1;
                end
                if (xfer_start) begin
                    if (eng_byte < 5 && eng_byte != cur.nodone) begin
                        eng_busy = 1'b1;
                        cd = int'(cur.lat[eng_byte]);
                    end
                    eng_byte++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT starts a byte or ends a frame.
    initial begin
        logic [1:0] prev;
        int fall_cyc [2];
        int starts [2];
        int rise0_cyc;
        bit rise0_valid;
        exp_t e;
        prev = 2'b11; rise0_cyc = 0; rise0_valid = 1'b0;
        fall_cyc[0] = 0; fall_cyc[1] = 0; starts[0] = 0; starts[1] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev = 2'b11;
                rise0_valid = 1'b0;
            end else begin
                if (xfer_start) begin
                    if (exp_tx_q.size() == 0) fail_event("unexpected_start");
                    else check("tx_byte", 32'(xfer_tx_byte), 32'(exp_tx_q.pop_front()));
                    if (!att_n[0]) starts[0]++;
                    else starts[1]++;
                end
                for (int p = 0; p < 2; p++) begin
                    if (prev[p] && !att_n[p]) begin
                        fall_count++;
                        fall_cyc[p] = cyc;
                        starts[p] = 0;
                        check("att_other_high", 32'(att_n[1-p]), 32'h1);
                        if (p == 1 && rise0_valid) check("att_hold", 32'(cyc - rise0_cyc), 32'(HOLD));
                        if (exp_q.size() == 0) fail_event("unexpected_frame");
                        else check("frame_port", 32'(p), 32'(exp_q[0].port));
                    end
                    if (!prev[p] && att_n[p]) begin
                        if (exp_q.size() == 0) begin
                            fail_event("unexpected_frame_end");
                        end else begin
                            e = exp_q.pop_front();
                            check("present", 32'(present[p]), 32'(e.ok));
                            check("buttons", 32'((p == 0) ? buttons0 : buttons1), 32'(e.buttons));
                            check("pad_id", 32'((p == 0) ? pad_id0 : pad_id1), 32'(e.pad));
                            check("update_stb", 32'(update_stb[p]), 32'(e.ok));
                            check("frame_starts", 32'(starts[p]), 32'(e.n_starts));
                            check("att_low_cycles", 32'(cyc - fall_cyc[p]), 32'(e.low_cycles));
                        end
                        if (p == 0) begin
                            rise0_cyc = cyc;
                            rise0_valid = 1'b1;
                        end
                    end else if (update_stb[p]) begin
                        fail_event("spurious_update_stb");
                    end
                end
                prev = att_n;
            end
        end
    end

    // Stimulus: scenario rounds, enable drop mid-round, reset mid-frame.
    initial begin
        scn_t s;
        int rel_cyc, i, fc;
        rst = 1'b1; enable = 1'b0;
        model_pad[0] = 8'h00; model_pad[1] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        enable = 1'b1;

        // Round 0: the reference pad on port 0; port 1 does not ACK byte 1.
        s.rx = {8'hFE, 8'h7F, 8'h5A, 8'h41, 8'hFF};
        s.ack = 5'b11111;
        s.lat = {8'd64, 8'd64, 8'd64, 8'd64, 8'd64};
        s.nodone = 5;
        issue(s, 0);
        s.ack[1] = 1'b0;
        issue(s, 1);
        // Round 1: bad 0x5A marker on port 0.
        s = rand_scn(1'b1); s.rx[2] = 8'h00; issue(s, 0);
        issue(rand_scn(1'b1), 1);
        // Round 2: the engine never completes port 0 byte 0.
        s = rand_scn(1'b1); s.nodone = 0; issue(s, 0);
        issue(rand_scn(1'b0), 1);
        for (int r = 3; r < 7; r++) begin
            issue(rand_scn(1'b0), 0);
            issue(rand_scn(1'b0), 1);
        end
        issue(rand_scn(1'b1), 0);   // round 7: enable drops during byte 2
        issue(rand_scn(1'b0), 1);

        rst = 1'b0;
        rel_cyc = cyc;
        i = 0;
        while (att_n[0] && i < POLL + 10) begin @(negedge clk); #1; i++; end
        check("first_round_start", 32'(cyc - rel_cyc), 32'(POLL));

        i = 0;
        while (att_n[1] && i < 3000) begin @(negedge clk); #1; i++; end
        check("p0_buttons_ref", 32'(buttons0), 32'hFE7F);
        check("p0_pad_id_ref", 32'(pad_id0), 32'h41);
        check("p0_present_ref", 32'(present[0]), 32'h1);
        i = 0;
        while (!att_n[1] && i < 3000) begin @(negedge clk); #1; i++; end
        check("p1_present_noack", 32'(present[1]), 32'h0);
        check("p1_buttons_noack", 32'(buttons1), 32'hFFFF);

        i = 0;
        while (!(exp_q.size() == 2 && !att_n[0] && eng_byte == 3) && i < 40000) begin
            @(negedge clk); #1; i++;
        end
        check("reach_enable_drop_point", 32'(eng_byte), 32'h3);
        enable = 1'b0;
        i = 0;
        while (exp_q.size() != 0 && i < 5000) begin @(negedge clk); #1; i++; end
        check("round_completes_after_drop", 32'(exp_q.size()), 32'h0);
        fc = fall_count;
        repeat (5 * POLL) @(negedge clk);
        #1;
        check("idle_att_n", 32'(att_n), 32'h3);
        check("idle_no_new_frames", 32'(fall_count), 32'(fc));

        // Re-enable: the saturated IDLE counter lets a round start at once.
        issue(rand_scn(1'b1), 0);
        issue(rand_scn(1'b0), 1);
        enable = 1'b1;
        i = 0;
        while (att_n[0] && i < POLL + 10) begin @(negedge clk); #1; i++; end
        check("reenable_round_start", 32'(att_n[0]), 32'h0);
        i = 0;
        while (!(eng_byte == 4 && eng_busy) && i < 3000) begin @(negedge clk); #1; i++; end
        check("reach_byte3_wait", 32'(eng_byte), 32'h4);

        // Reset during WAIT of byte 3, then a spurious done while idle.
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs();
        scn_q.delete(); exp_q.delete(); exp_tx_q.delete();
        model_pad[0] = 8'h00; model_pad[1] = 8'h00;
        rst = 1'b0;
        rel_cyc = cyc;
        spur_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            issue(rand_scn(1'b0), 0);
            issue(rand_scn(1'b0), 1);
        end
        i = 0;
        while (att_n[0] && i < POLL + 10) begin @(negedge clk); #1; i++; end
        check("resume_after_reset", 32'(cyc - rel_cyc), 32'(POLL));
        i = 0;
        while (exp_q.size() > 1 && i < 20000) begin @(negedge clk); #1; i++; end
        enable = 1'b0;
        i = 0;
        while (exp_q.size() != 0 && i < 5000) begin @(negedge clk); #1; i++; end
        repeat (50) @(negedge clk);
        #1;
        check("all_frames_seen", 32'(exp_q.size()), 32'h0);
        check("all_starts_seen", 32'(exp_tx_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
